// File: rtl/ann_pkg.sv
// Shared types and arithmetic helpers for the ANN datapath blocks.
package ann_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Arguments are the sign bits of both addends and of the wrapped sum.
  function automatic logic add_ovf(input logic a, input logic b, input logic sum);
    return (a == b) && (sum != a);
  endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Partial-sum input stream and pre-activation output stream of the neuron accumulator.
interface neuron_accumulator_if #(
  parameter int DATA_W = ann_pkg::DATA_W_DEF
);

  logic                     clear;
  logic signed [DATA_W-1:0] bias;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_ovf;
  logic                     out_ready;

  modport master (
    output clear, bias, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  clear, bias, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/neuron_accumulator.sv
// Adds a per-neuron bias to N_TERMS partial-sum beats and presents the wrapped
// pre-activation plus a sticky signed-overflow flag through a valid/ready handshake.
module neuron_accumulator
  import ann_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_TERMS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  neuron_accumulator_if.slave  bus
);

  localparam int              CNT_W    = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;

  logic                     in_ready;
  logic                     accept;
  logic                     first_beat;
  logic signed [DATA_W-1:0] addend;
  logic signed [DATA_W-1:0] sum;
  logic                     sum_ovf;
  logic                     ovf_acc;
  logic [CNT_W-1:0]         cnt_next;

  // A held result frees the input only when it is being retired this same cycle.
  assign in_ready   = !bus.clear && ((state_q != HOLD) || bus.out_ready);
  assign accept     = bus.in_valid && in_ready;
  assign first_beat = (state_q != ACCUM);
  assign addend     = first_beat ? bus.bias : acc_q;
  assign sum        = addend + bus.in_data;
  assign sum_ovf    = add_ovf(addend[DATA_W-1], bus.in_data[DATA_W-1], sum[DATA_W-1]);
  assign ovf_acc    = sum_ovf || (!first_beat && ovf_q);
  assign cnt_next   = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (bus.clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if ((state_q == HOLD) && bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      // A beat taken while retiring overrides the retire defaults above.
      if (accept) begin
        acc_d = sum;
        ovf_d = ovf_acc;
        if (cnt_next == LAST_CNT) begin
          out_data_d  = sum;
          out_ovf_d   = ovf_acc;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = HOLD;
        end else begin
          cnt_d   = cnt_next;
          state_d = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench: a per-cycle vector table on an N_TERMS=4 instance, then a
// hand-written back-to-back sequence on an N_TERMS=1 instance.
module tb_neuron_accumulator;

  logic clk;
  logic rst_n;

  neuron_accumulator_if #(.DATA_W(32)) if4 ();
  neuron_accumulator_if #(.DATA_W(32)) if1 ();

  neuron_accumulator #(.DATA_W(32), .N_TERMS(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  neuron_accumulator #(.DATA_W(32), .N_TERMS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        clear;
    logic [31:0] bias;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic        chk_data;
    logic [31:0] exp_out_data;
    logic        exp_out_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // r=rst_n c=clear b=bias v=in_valid d=in_data o=out_ready | in_ready, out_valid, chk, data, ovf
  task automatic add(input logic r, input logic c, input logic [31:0] b, input logic v,
                     input logic [31:0] d, input logic o, input logic eir, input logic eov,
                     input logic chk, input logic [31:0] ed, input logic eovf);
    vec_t t;
    t.rst_n = r; t.clear = c; t.bias = b; t.in_valid = v; t.in_data = d; t.out_ready = o;
    t.exp_in_ready = eir; t.exp_out_valid = eov; t.chk_data = chk;
    t.exp_out_data = ed; t.exp_out_ovf = eovf;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0;
    if4.clear = 0; if4.bias = '0; if4.in_valid = 0; if4.in_data = '0; if4.out_ready = 0;
    if1.clear = 0; if1.bias = '0; if1.in_valid = 0; if1.in_data = '0; if1.out_ready = 0;

    // Basic accumulate: 10+1+2+3+4
    add(1,0,32'd10,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd10,1,32'd2,1, 1,0,0,0,0);
    add(1,0,32'd10,1,32'd3,1, 1,0,0,0,0);
    add(1,0,32'd10,1,32'd4,1, 1,1,1,32'd20,0);
    add(1,0,32'd0, 0,32'd0,1, 1,0,1,32'd20,0);
    // Neuron A held under backpressure, B's first beat stalls, then zero-bubble handover
    add(1,0,32'd0,1,32'd5,0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,0, 1,1,1,32'd20,0);
    add(1,0,32'd1,1,32'd1,0, 0,1,1,32'd20,0);
    add(1,0,32'd1,1,32'd1,0, 0,1,1,32'd20,0);
    add(1,0,32'd1,1,32'd1,0, 0,1,1,32'd20,0);
    add(1,0,32'd1,1,32'd1,1, 1,0,1,32'd20,0);
    add(1,0,32'd9,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd9,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd9,1,32'd1,1, 1,1,1,32'd5,0);
    add(1,0,32'd0,0,32'd0,1, 1,0,0,0,0);
    // Positive overflow, then back-to-back neuron with ovf cleared
    add(1,0,32'h7FFFFFFF,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'h7FFFFFFF,1,32'd0,1, 1,0,0,0,0);
    add(1,0,32'h7FFFFFFF,1,32'd0,1, 1,0,0,0,0);
    add(1,0,32'h7FFFFFFF,1,32'd0,1, 1,1,1,32'h80000000,1);
    add(1,0,32'd0,1,32'd1,1, 1,0,1,32'h80000000,1);
    add(1,0,32'd0,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd1,1, 1,1,1,32'd4,0);
    add(1,0,32'd0,0,32'd0,1, 1,0,0,0,0);
    // Gaps: 2+3+4+5+6, bias change and junk data during gaps ignored
    add(1,0,32'd2, 1,32'd3, 1, 1,0,0,0,0);
    add(1,0,32'd77,0,32'd99,1, 1,0,0,0,0);
    add(1,0,32'd77,0,32'd99,1, 1,0,0,0,0);
    add(1,0,32'd77,1,32'd4, 1, 1,0,0,0,0);
    add(1,0,32'd77,0,32'd0, 1, 1,0,0,0,0);
    add(1,0,32'd77,1,32'd5, 1, 1,0,0,0,0);
    add(1,0,32'd77,1,32'd6, 1, 1,1,1,32'd20,0);
    add(1,0,32'd0, 0,32'd0, 1, 1,0,0,0,0);
    // Clear mid-neuron: beat offered during clear is not consumed
    add(1,0,32'd0,1,32'd7,  1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd7,  1, 1,0,0,0,0);
    add(1,1,32'd0,1,32'd100,1, 0,0,1,32'd20,0);
    add(1,0,32'd0,1,32'd1,  0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd2,  0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd3,  0, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd4,  0, 1,1,1,32'd10,0);
    // Clear while holding: result dropped without handshake, out_data kept
    add(1,1,32'd0,0,32'd0,0, 0,0,1,32'd10,0);
    add(1,0,32'd0,0,32'd0,0, 1,0,1,32'd10,0);
    // Sticky overflow: 0x7FFFFFFF+1 overflows, later adds come back to 0
    add(1,0,32'h7FFFFFFF,1,32'd1,        1, 1,0,0,0,0);
    add(1,0,32'd0,       1,32'h7FFFFFFF, 1, 1,0,0,0,0);
    add(1,0,32'd0,       1,32'd1,        1, 1,0,0,0,0);
    add(1,0,32'd0,       1,32'd0,        1, 1,1,1,32'd0,1);
    add(1,0,32'd0,       0,32'd0,        1, 1,0,0,0,0);
    // Negative overflow: 0x80000000 + (-1)
    add(1,0,32'h80000000,1,32'hFFFFFFFF,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd0,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd0,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd0,1, 1,1,1,32'h7FFFFFFF,1);
    add(1,0,32'd0,0,32'd0,1, 1,0,0,0,0);
    // Reset during ACCUM after a nonzero result: outputs return to zero
    add(1,0,32'd0,1,32'd5,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd5,1, 1,1,1,32'd20,0);
    add(1,0,32'd0,0,32'd0,1, 1,0,1,32'd20,0);
    add(1,0,32'd0,1,32'd2,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd2,1, 1,0,0,0,0);
    add(0,0,32'd0,1,32'd2,1, 1,0,1,32'd0,0);
    add(1,0,32'd0,1,32'd1,1, 1,0,1,32'd0,0);
    add(1,0,32'd0,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd1,1, 1,0,0,0,0);
    add(1,0,32'd0,1,32'd1,1, 1,1,1,32'd4,0);
    add(1,0,32'd0,0,32'd0,1, 1,0,0,0,0);

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready4",  32'(if4.in_ready),  32'd1);
    check("rst_out_valid4", 32'(if4.out_valid), 32'd0);
    check("rst_out_data4",  if4.out_data,       32'd0);
    check("rst_out_ovf4",   32'(if4.out_ovf),   32'd0);
    check("rst_in_ready1",  32'(if1.in_ready),  32'd1);
    check("rst_out_valid1", 32'(if1.out_valid), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n         = tbl[i].rst_n;
      if4.clear     = tbl[i].clear;
      if4.bias      = tbl[i].bias;
      if4.in_valid  = tbl[i].in_valid;
      if4.in_data   = tbl[i].in_data;
      if4.out_ready = tbl[i].out_ready;
      #1;
      check($sformatf("in_ready[%0d]", i), 32'(if4.in_ready), 32'(tbl[i].exp_in_ready));
      @(negedge clk);
      check($sformatf("out_valid[%0d]", i), 32'(if4.out_valid), 32'(tbl[i].exp_out_valid));
      if (tbl[i].chk_data) begin
        check($sformatf("out_data[%0d]", i), if4.out_data,        tbl[i].exp_out_data);
        check($sformatf("out_ovf[%0d]", i),  32'(if4.out_ovf),    32'(tbl[i].exp_out_ovf));
      end
    end
    rst_n = 1'b1;
    if4.in_valid = 0; if4.clear = 0;

    // N_TERMS=1: every beat is a complete neuron; out_valid stays high back-to-back
    if1.bias = 32'd3; if1.in_valid = 1; if1.in_data = 32'd4; if1.out_ready = 1;
    #1 check("n1_in_ready_a", 32'(if1.in_ready), 32'd1);
    @(negedge clk);
    check("n1_valid_a", 32'(if1.out_valid), 32'd1);
    check("n1_data_a",  if1.out_data,       32'd7);
    if1.in_data = 32'd5;
    #1 check("n1_in_ready_b", 32'(if1.in_ready), 32'd1);
    @(negedge clk);
    check("n1_valid_b", 32'(if1.out_valid), 32'd1);
    check("n1_data_b",  if1.out_data,       32'd8);
    check("n1_ovf_b",   32'(if1.out_ovf),   32'd0);
    if1.in_data = 32'd1; if1.out_ready = 0;
    #1 check("n1_in_ready_stall", 32'(if1.in_ready), 32'd0);
    @(negedge clk);
    check("n1_valid_stall", 32'(if1.out_valid), 32'd1);
    check("n1_data_stall",  if1.out_data,       32'd8);
    if1.bias = 32'h80000000; if1.in_data = 32'hFFFFFFFF; if1.out_ready = 1;
    @(negedge clk);
    check("n1_valid_ovf", 32'(if1.out_valid), 32'd1);
    check("n1_data_ovf",  if1.out_data,       32'h7FFFFFFF);
    check("n1_ovf",       32'(if1.out_ovf),   32'd1);
    if1.in_valid = 0;
    @(negedge clk);
    check("n1_valid_idle", 32'(if1.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
